// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, fixed
// WIDTH-cycle run after start. done is asserted on the final step, and product
// already includes that step's contribution so the caller can register it.
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH-1:0] acc_d;

  // Accumulator next value for the current step (add multiplicand when LSB set).
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign done    = run_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_d;

  // Operand capture on start, then one shift-add step per cycle until the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= A;
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered output stage. Single-cycle ops land in HOLD
// one cycle after accept; MUL runs through the iterative multiplier for WIDTH
// cycles. HOLD passes in_ready through from out_ready for 1 op/cycle throughput.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUcontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal,
  output logic             busy
);

  state_e           state_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, ovf_q, ovf_d, ill_q, ill_d;
  logic             vld_q, busy_q;
  logic [WIDTH-1:0] sum, diff;
  logic             accept, is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (ALUcontrol == OP_MUL);

  assign sum  = A + B;
  assign diff = A - B;

  // Single-cycle result, overflow and illegal decode from the live inputs.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    ill_d = 1'b0;
    case (ALUcontrol)
      OP_AND: res_d = A & B;
      OP_OR:  res_d = A | B;
      OP_ADD: begin
        res_d = sum;
        ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: res_d = ~(A | B);
      default: ill_d = 1'b1;  // MUL is handled by the FSM when enabled
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Control FSM; result and flags are always written together as one set.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= MUL_RUN;
              vld_q   <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= HOLD;
              vld_q   <= 1'b1;
              res_q   <= res_d;
              zero_q  <= (res_d == '0);
              ovf_q   <= ovf_d;
              ill_q   <= ill_d;
            end
          end else if (vld_q && out_ready) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
          end
        end
        MUL_RUN: begin
          if (mul_done) begin
            state_q <= HOLD;
            vld_q   <= 1'b1;
            busy_q  <= 1'b0;
            res_q   <= mul_product;
            zero_q  <= (mul_product == '0);
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = vld_q;
  assign ALUresult = res_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Illegal   = ill_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=8: directed scenarios plus randomized traffic,
// all checked every cycle against an arithmetic reference and transaction queue.
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int M    = 1 << W;
  localparam int MAXS = (1 << (W - 1)) - 1;
  localparam int MINS = -(1 << (W - 1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT with multiplier
  logic         iv, ir, ovld, ordy, zf, of, il, bsy;
  logic [W-1:0] a, b, res;
  logic [3:0]   op;

  // DUT without multiplier
  logic         iv1, ir1, ovld1, ordy1, zf1, of1, il1, bsy1;
  logic [W-1:0] a1, b1, res1;
  logic [3:0]   op1;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
    .ALUcontrol(op), .out_valid(ovld), .out_ready(ordy), .ALUresult(res),
    .Zero(zf), .Overflow(of), .Illegal(il), .busy(bsy)
  );

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .ALUcontrol(op1), .out_valid(ovld1), .out_ready(ordy1), .ALUresult(res1),
    .Zero(zf1), .Overflow(of1), .Illegal(il1), .busy(bsy1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         z, ov, ill;
    int           due;
  } exp_t;

  exp_t q[$];
  int   mul_due = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t   e;
    longint ua, ub, sa, sb, r;
    ua = longint'(xa);
    ub = longint'(xb);
    sa = (ua > MAXS) ? ua - M : ua;
    sb = (ub > MAXS) ? ub - M : ub;
    r = 0;
    e.ov = 1'b0;
    e.ill = 1'b0;
    e.due = 0;
    case (o)
      4'b0000: r = ua & ub;
      4'b0001: r = ua | ub;
      4'b0010: begin r = (ua + ub) % M; e.ov = (sa + sb > MAXS) || (sa + sb < MINS); end
      4'b0110: begin r = (ua - ub + M) % M; e.ov = (sa - sb > MAXS) || (sa - sb < MINS); end
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b1100: r = (M - 1) - (ua | ub);
      4'b1000: r = (ua * ub) % M;
      default: begin r = 0; e.ill = 1'b1; end
    endcase
    e.res = W'(r);
    e.z = (r == 0);
    return e;
  endfunction

  // Per-cycle comparison of u0 against the reference queue.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      mul_due = 0;
    end else begin
      chk("busy", bsy, cyc < mul_due);
      chk("in_ready", ir, (cyc >= mul_due) && (q.size() == 0 || ordy));
      chk("out_valid", ovld, (q.size() > 0) && (cyc >= q[0].due));
      if (ovld && q.size() > 0) begin
        chk("result", res, q[0].res);
        chk("zero", zf, q[0].z);
        chk("overflow", of, q[0].ov);
        chk("illegal", il, q[0].ill);
        if (ordy) void'(q.pop_front());
      end
      if (iv && ir) begin
        exp_t e;
        e = model(op, a, b);
        if (op == 4'b1000) begin
          e.due = cyc + 1 + W;
          mul_due = e.due;
        end else begin
          e.due = cyc + 1;
        end
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    iv = 1'b1; op = o; a = x; b = y;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(MAXS);
      2: return W'(M / 2);
      3: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    exp_t pin;
    iv = 0; op = 0; a = 0; b = 0; ordy = 1;
    iv1 = 0; op1 = 0; a1 = 0; b1 = 0; ordy1 = 1;

    // Model pins
    pin = model(4'b1000, 8'h0D, 8'h0B);
    chk("model mul", pin.res, 8'h8F);
    pin = model(4'b0010, 8'h7F, 8'h01);
    chk("model add ovf", {pin.res, pin.ov}, {8'h80, 1'b1});
    pin = model(4'b0110, 8'h80, 8'h01);
    chk("model sub ovf", {pin.res, pin.ov}, {8'h7F, 1'b1});

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst out_valid", ovld, 0);
    chk("rst result", res, 0);
    chk("rst flags", {zf, of, il, bsy}, 4'b0000);
    chk("rst in_ready", ir, 1);

    // Back-to-back single-cycle ops
    tick(); drive(4'b0010, 8'h7F, 8'h01);
    tick(); drive(4'b0110, 8'h05, 8'h05);
    #1 chk("add", {ovld, res, of}, {1'b1, 8'h80, 1'b1});
    tick(); drive(4'b0111, 8'hFF, 8'h01);
    #1 chk("sub", {ovld, res, zf}, {1'b1, 8'h00, 1'b1});
    tick(); drive(4'b1100, 8'hF0, 8'h0F);
    #1 chk("slt", {ovld, res}, {1'b1, 8'h01});
    tick(); iv = 0;
    #1 chk("nor", {ovld, res, zf}, {1'b1, 8'h00, 1'b1});

    // Multiply latency
    tick(); drive(4'b1000, 8'h0D, 8'h0B);
    tick(); iv = 0;
    #1 chk("mul busy", {ovld, bsy, ir}, 3'b010);
    for (int i = 0; i < W - 1; i++) begin
      tick(); #1 chk("mul busy", {ovld, bsy, ir}, 3'b010);
    end
    tick(); #1 chk("mul result", {ovld, res, bsy}, {1'b1, 8'h8F, 1'b0});

    // Backpressure
    tick(); ordy = 0; drive(4'b0010, 8'h30, 8'h0C);
    tick(); drive(4'b0000, 8'hFF, 8'h0F);
    #1 chk("bp hold", {ovld, res, ir}, {1'b1, 8'h3C, 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick(); #1 chk("bp hold", {ovld, res, ir}, {1'b1, 8'h3C, 1'b0});
    end
    ordy = 1;
    tick(); iv = 0;
    #1 chk("bp release", {ovld, res}, {1'b1, 8'h0F});

    // Illegal opcode
    tick(); drive(4'b0101, 8'hAA, 8'h00);
    tick(); iv = 0;
    #1 chk("illegal", {ovld, res, il, zf}, {1'b1, 8'h00, 1'b1, 1'b1});

    // MUL decodes illegal without the multiplier
    iv1 = 1; op1 = 4'b1000; a1 = 8'h03; b1 = 8'h05;
    tick(); op1 = 4'b0010;
    #1 chk("nomul illegal", {ovld1, res1, il1, zf1, bsy1}, {1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
    tick(); iv1 = 0;
    #1 chk("nomul add", {ovld1, res1, il1}, {1'b1, 8'h08, 1'b0});

    // Reset during multiply
    tick(); drive(4'b1000, 8'hFF, 8'hFF);
    tick(); iv = 0;
    tick();
    tick(); reset = 1;
    tick(); reset = 0;
    #1 chk("abort idle", {ovld, bsy, ir}, 3'b001);
    repeat (W + 2) tick();
    drive(4'b0010, 8'h02, 8'h03);
    tick(); iv = 0;
    #1 chk("post-abort add", {ovld, res}, {1'b1, 8'h05});

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b0110;
        4: op = 4'b0111;
        5: op = 4'b1100;
        6, 7: op = 4'b1000;
        8: op = 4'($urandom);
        default: op = 4'b0010;
      endcase
      a = pick();
      b = pick();
    end
    tick(); reset = 0; iv = 0; ordy = 1;
    repeat (W + 4) tick();
    chk("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the datapath's combinational 64-bit ALU.
- Registers every result behind a valid/ready output stage.
- Implements the full opcode set, including SLT and NOR.
- Adds an iterative shift-add multiply (MUL), plus overflow and illegal-opcode flags.
- Sits between the register-file read stage and writeback; the upstream decode stage must stall on in_ready.

Parameters:
- WIDTH, 64: operand and result width in bits; minimum 2.
- MUL_EN, 1: when 1, MUL is implemented; when 0, MUL decodes as illegal.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  A, B and ALUcontrol are valid this cycle.
- in_ready  output  1  the block accepts an operation this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUcontrol  input  4  opcode.
- out_valid  output  1  ALUresult and the flags are valid.
- out_ready  input  1  downstream consumes the result this cycle.
- ALUresult  output  WIDTH  registered result.
- Zero  output  1  high when ALUresult == 0 (registered, valid with out_valid).
- Overflow  output  1  signed overflow for ADD/SUB; 0 for all other opcodes.
- Illegal  output  1  the opcode was unsupported; ALUresult is 0.
- busy  output  1  a multiply is in progress.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, ALUresult=0, Zero=0, Overflow=0, Illegal=0, busy=0, state=IDLE. in_ready is 1 in the cycle after reset deasserts.
- Reset asserted mid-multiply aborts it. The partial product is discarded and nothing is emitted.
- Opcodes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD, modulo 2^WIDTH.
  - 0110 SUB, A-B modulo 2^WIDTH.
  - 0111 SLT: signed compare; result is 1 when A<B, else 0, zero-extended to WIDTH.
  - 1100 NOR.
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - Any other code: result 0 with Illegal=1.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
- Handshake:
  - An operation transfers in when in_valid && in_ready.
  - A result transfers out when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- States:
  - IDLE: out_valid=0, in_ready=1.
    - Accept of a non-MUL op → HOLD, with the result registered; latency is 1 cycle.
    - Accept of MUL → MUL_RUN with count=0; A and B are captured into internal registers.
  - MUL_RUN: in_ready=0, busy=1.
    - Each cycle: if the multiplier LSB is 1, add the multiplicand into the accumulator. Then shift the multiplicand left and the multiplier right, and increment count.
    - When count==WIDTH-1 → HOLD, carrying the final product.
    - Accept-to-out_valid latency is WIDTH cycles.
    - Early termination is not permitted; latency is fixed.
  - HOLD: out_valid=1, in_ready=out_ready (pass-through accept).
    - out_ready && in_valid && non-MUL → stay in HOLD with the new result. This gives back-to-back throughput of 1 op/cycle.
    - out_ready && in_valid && MUL → MUL_RUN.
    - out_ready && !in_valid → IDLE.
    - !out_ready → stay in HOLD, no change.
- Zero, Overflow and Illegal are registered together with ALUresult, always as a coherent set.
- Input operands are sampled only on accept. Changes to A, B or ALUcontrol at any other time have no effect.
- The MUL counter is $clog2(WIDTH) bits wide. No wrap beyond WIDTH-1 is reachable.

Decomposition:
- Shared package alu_pkg holds the opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL.
- alu_pkg also holds the state encoding: IDLE, MUL_RUN, HOLD.
- Sub-module alu_mul_iter: the iterative shift-add multiplier.
  - Interface: start, A, B, done, product, parameterised by WIDTH.
  - Instantiated only when MUL_EN=1.
- The combinational single-cycle ops stay in alu_pipe.

Test Plan:
- Reset then idle → all outputs 0, in_ready=1 on the first post-reset cycle.
- WIDTH=8, back-to-back ops with out_ready=1:
  - ADD 0x7F+0x01 → 0x80, Overflow=1.
  - SUB 0x05-0x05 → 0x00, Zero=1.
  - SLT 0xFF,0x01 → 0x01.
  - NOR 0xF0,0x0F → 0x00.
  - Results appear on consecutive cycles, each one cycle after its accept.
- WIDTH=8, MUL 0x0D*0x0B → ALUresult=0x8F; out_valid exactly 8 cycles after accept; in_ready=0 and busy=1 throughout.
- Backpressure: hold out_ready=0 for 5 cycles while HOLD contains 0x3C → outputs are stable, in_ready=0, and a pending op is not accepted until out_ready rises.
- Illegal opcode 0101 with A=0xAA → ALUresult=0, Illegal=1, Zero=1; MUL_EN=0 with opcode 1000 → Illegal=1 and 1-cycle latency.
- Reset asserted on cycle 3 of a MUL → out_valid never rises for that op; IDLE on the next cycle; a subsequent ADD 2+3 → 5.
